// File: rtl/pipelined_array_mult.sv
// pipelined_array_mult: valid/ready array multiplier that reduces one
// partial-product row per pipeline stage, with per-transaction signed or
// unsigned operation, a global stall and a synchronous flush.
module pipelined_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;

  // Widen an operand to product width; sign bits are replicated only in signed mode.
  function automatic logic [PW-1:0] extendOperand(input logic [WIDTH-1:0] v, input logic s);
    extendOperand = {{WIDTH{s & v[WIDTH-1]}}, v};
  endfunction

  logic [WIDTH-1:0]           valid_q, valid_d;
  logic [WIDTH-1:0][WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0][WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0]           isSigned_q, isSigned_d;
  logic [WIDTH-1:0][PW-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0][PW-1:0]   rowTerm;
  logic                       advance;
  logic                       unusedBits;

  // The whole pipeline moves together unless a finished result is waiting on the consumer.
  assign advance   = ~valid_q[WIDTH-1] | out_ready;
  assign in_ready  = advance & ~flush;
  assign out_valid = valid_q[WIDTH-1];
  assign out_p     = sum_q[WIDTH-1];
  assign busy      = |valid_q;

  // The last stage's operands and most multiplier bits are carried only so every stage holds a full transaction.
  assign unusedBits = ^{opA_q[WIDTH-1], opB_q, isSigned_q[WIDTH-1]};

  // Row i is the (possibly sign-extended) multiplicand gated by multiplier bit i and shifted into place.
  always_comb begin
    rowTerm    = '0;
    rowTerm[0] = in_b[0] ? extendOperand(in_a, in_signed) : '0;
    for (int i = 1; i < WIDTH; i++) begin
      rowTerm[i] = opB_q[i-1][i] ? (extendOperand(opA_q[i-1], isSigned_q[i-1]) << i) : '0;
    end
  end

  // Next state: flush drops every valid bit but keeps data; otherwise shift on advance, hold on stall.
  always_comb begin
    valid_d    = valid_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    isSigned_d = isSigned_q;
    sum_d      = sum_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d[0]    = in_valid;
      opA_d[0]      = in_a;
      opB_d[0]      = in_b;
      isSigned_d[0] = in_signed;
      sum_d[0]      = rowTerm[0];
      for (int i = 1; i < WIDTH; i++) begin
        valid_d[i]    = valid_q[i-1];
        opA_d[i]      = opA_q[i-1];
        opB_d[i]      = opB_q[i-1];
        isSigned_d[i] = isSigned_q[i-1];
        // The top multiplier bit weighs -2^(WIDTH-1) in two's complement, so its row is subtracted.
        if (isSigned_q[i-1] && (i == WIDTH - 1)) begin
          sum_d[i] = sum_q[i-1] - rowTerm[i];
        end else begin
          sum_d[i] = sum_q[i-1] + rowTerm[i];
        end
      end
    end
  end

  // Stage registers with asynchronous clear of both valid bits and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      isSigned_q <= '0;
      sum_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      isSigned_q <= isSigned_d;
      sum_q      <= sum_d;
    end
  end

endmodule

// File: tb/tb_pipelined_array_mult.sv
// tb_pipelined_array_mult: drives a WIDTH=4 and a WIDTH=8 multiplier and
// compares them cycle by cycle against a shift-register-of-products model.
module tb_pipelined_array_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       iv[2], isg[2], ordy[2], fl[2];
  logic [7:0] ia[2], ib[2];
  logic       irdy[2], ov[2], bsy[2];
  logic [7:0]  op4;
  logic [15:0] op8;

  int widthOf[2] = '{4, 8};

  // Reference model: one slot per pipeline stage holding a finished product.
  bit mv[2][8];
  int mp[2][8];
  int accepted[2];
  int retired[2];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  pipelined_array_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(ia[0][3:0]), .in_b(ib[0][3:0]), .in_signed(isg[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_p(op4), .busy(bsy[0])
  );

  pipelined_array_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(ia[1]), .in_b(ib[1]), .in_signed(isg[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_p(op8), .busy(bsy[1])
  );

  // Runaway guard so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int refProduct(int a, int b, bit s, int w);
    int sa, sb;
    sa = a;
    sb = b;
    if (s && (((a >> (w - 1)) & 1) == 1)) sa = a - (1 << w);
    if (s && (((b >> (w - 1)) & 1) == 1)) sb = b - (1 << w);
    return (sa * sb) & ((1 << (2 * w)) - 1);
  endfunction

  function automatic int outP(int d);
    return (d == 0) ? int'(op4) : int'(op8);
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        mv[d][i] = 1'b0;
        mp[d][i] = 0;
      end
  endtask

  task automatic checkOutput(int d);
    int w;
    bit adv, anyValid;
    w = widthOf[d];
    adv = !mv[d][w-1] || ordy[d];
    anyValid = 1'b0;
    for (int i = 0; i < w; i++) anyValid |= mv[d][i];
    check($sformatf("w%0d out_valid", w), int'(ov[d]), int'(mv[d][w-1]));
    if (mv[d][w-1]) check($sformatf("w%0d out_p", w), outP(d), mp[d][w-1]);
    check($sformatf("w%0d in_ready", w), int'(irdy[d]), int'(adv && !fl[d]));
    check($sformatf("w%0d busy", w), int'(bsy[d]), int'(anyValid));
  endtask

  task automatic modelStep(int d);
    int w, mask;
    bit adv;
    w = widthOf[d];
    mask = (1 << w) - 1;
    adv = !mv[d][w-1] || ordy[d];
    if (fl[d]) begin
      for (int i = 0; i < 8; i++) mv[d][i] = 1'b0;
    end else if (adv) begin
      if (mv[d][w-1]) retired[d]++;
      for (int i = w - 1; i > 0; i--) begin
        mv[d][i] = mv[d][i-1];
        mp[d][i] = mp[d][i-1];
      end
      mv[d][0] = iv[d];
      mp[d][0] = refProduct(int'(ia[d]) & mask, int'(ib[d]) & mask, isg[d], w);
      if (iv[d]) accepted[d]++;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput(0);
    checkOutput(1);
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int startAcc, startRet, cycles;
    logic [7:0] held;

    vecs[0] = '{a: 4'd13, b: 4'd11, s: 1'b0, exp: 8'h8F};
    vecs[1] = '{a: 4'd15, b: 4'd15, s: 1'b0, exp: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  s: 1'b0, exp: 8'h00};
    vecs[3] = '{a: 4'h8,  b: 4'h8,  s: 1'b1, exp: 8'h40};
    vecs[4] = '{a: 4'h8,  b: 4'h7,  s: 1'b1, exp: 8'hC8};
    vecs[5] = '{a: 4'hF,  b: 4'hF,  s: 1'b1, exp: 8'h01};

    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; isg[d] = 0; ordy[d] = 1; fl[d] = 0; ia[d] = 0; ib[d] = 0;
      accepted[d] = 0; retired[d] = 0;
    end
    modelReset();

    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid4", int'(ov[0]), 0);
    check("reset busy4", int'(bsy[0]), 0);
    check("reset out_p4", int'(op4), 0);
    check("reset out_valid8", int'(ov[1]), 0);
    check("reset busy8", int'(bsy[1]), 0);
    check("reset out_p8", int'(op8), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors: one isolated transaction each, result expected after three further edges.
    for (int k = 0; k < 6; k++) begin
      ia[0] = {4'b0, vecs[k].a};
      ib[0] = {4'b0, vecs[k].b};
      isg[0] = vecs[k].s;
      iv[0] = 1;
      applyStimulus();
      iv[0] = 0;
      repeat (3) applyStimulus();
      #2;
      check($sformatf("vec%0d out_valid", k), int'(ov[0]), 1);
      check($sformatf("vec%0d out_p", k), int'(op4), int'(vecs[k].exp));
      applyStimulus();
    end

    // Exhaustive back-to-back stream of every operand pair in both modes.
    startRet = retired[0];
    for (int k = 0; k < 512; k++) begin
      ia[0] = 8'(k & 15);
      ib[0] = 8'((k >> 4) & 15);
      isg[0] = ((k >> 8) & 1) == 1;
      iv[0] = 1;
      applyStimulus();
    end
    iv[0] = 0;
    repeat (6) applyStimulus();
    check("exhaustive retired", retired[0] - startRet, 512);

    // Backpressure: fill, stall five cycles with input pending, then drain.
    startAcc = accepted[0];
    startRet = retired[0];
    for (int k = 0; k < 4; k++) begin
      ia[0] = 8'(3 + k); ib[0] = 8'(5 + k); isg[0] = k[0]; iv[0] = 1;
      applyStimulus();
    end
    ordy[0] = 0;
    ia[0] = 8'd7; ib[0] = 8'd9; isg[0] = 0;
    #1;
    held = op4;
    check("stall out_valid start", int'(ov[0]), 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      check("stall out_valid", int'(ov[0]), 1);
      check("stall out_p", int'(op4), int'(held));
      check("stall in_ready", int'(irdy[0]), 0);
    end
    ordy[0] = 1;
    applyStimulus();
    iv[0] = 0;
    repeat (8) applyStimulus();
    check("stall accepted", accepted[0] - startAcc, 5);
    check("stall retired", retired[0] - startRet, 5);

    // Flush with three in flight and a pending input.
    for (int k = 0; k < 3; k++) begin
      ia[0] = 8'(9 + k); ib[0] = 8'(2 + k); isg[0] = 1; iv[0] = 1;
      applyStimulus();
    end
    fl[0] = 1;
    #1;
    check("flush in_ready", int'(irdy[0]), 0);
    applyStimulus();
    fl[0] = 0;
    iv[0] = 0;
    #2;
    check("flush busy", int'(bsy[0]), 0);
    check("flush out_valid", int'(ov[0]), 0);
    repeat (2) applyStimulus();

    // Asynchronous reset between edges with a live result at the output.
    ia[0] = 8'd13; ib[0] = 8'd11; isg[0] = 0; iv[0] = 1;
    repeat (4) applyStimulus();
    iv[0] = 0;
    check("pre-reset out_valid", int'(ov[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", int'(ov[0]), 0);
    check("async reset out_p", int'(op4), 0);
    check("async reset busy", int'(bsy[0]), 0);
    modelReset();
    #1 rst_n = 1'b1;
    repeat (2) applyStimulus();

    // Random WIDTH=8 stream with random backpressure.
    startAcc = accepted[1];
    startRet = retired[1];
    cycles = 0;
    while ((accepted[1] - startAcc) < 10000 && cycles < 60000) begin
      iv[1] = ($urandom_range(0, 9) != 0);
      ia[1] = 8'($urandom);
      ib[1] = 8'($urandom);
      isg[1] = 1'($urandom_range(0, 1));
      ordy[1] = ($urandom_range(0, 3) != 0);
      applyStimulus();
      cycles++;
    end
    iv[1] = 0;
    ordy[1] = 1;
    repeat (10) applyStimulus();
    check("random accepted", accepted[1] - startAcc, 10000);
    check("random retired", retired[1] - startRet, accepted[1] - startAcc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
